// File: rtl/axil_reg_master.sv
// AXI4-Lite register initiator: one command in, one AXI4-Lite transaction out, one response back.
// Optional B/R watchdog is compiled in with `define AXIL_REG_MASTER_TIMEOUT_EN (limit TIMEOUT_CYCLES).
module axil_reg_master #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    m_axi_aclk,
  input  logic                    m_axi_aresetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(3);

  if (DATA_WIDTH != 32 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("axil_reg_master: DATA_WIDTH must be 32 and TIMEOUT_CYCLES >= 2");
  end

  state_t                  state, state_next;
  logic                    live;
  logic                    aw_done, w_done;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic                    timeout_q;
  logic                    cmd_fire, aw_fire, w_fire, expired;

  assign cmd_fire = cmd_valid & cmd_ready;
  assign aw_fire  = m_axi_awvalid & m_axi_awready;
  assign w_fire   = m_axi_wvalid & m_axi_wready;

`ifdef AXIL_REG_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] count;

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      count <= '0;
    end else if (cmd_fire) begin
      count <= '0;
    end else if (state != IDLE && state != RSP && count != CNT_W'(TIMEOUT_CYCLES)) begin
      count <= count + CNT_W'(1);
    end
  end

  // count lags the cycle index by one, so firing at TIMEOUT_CYCLES-2 puts rsp_valid
  // exactly TIMEOUT_CYCLES cycles after acceptance.
  assign expired = (state == WR_RESP || state == RD_RESP) &&
                   (count >= CNT_W'(TIMEOUT_CYCLES - 2));
`else
  assign expired = 1'b0;
`endif

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next    = state;
    cmd_ready     = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    rsp_valid     = 1'b0;
    unique case (state)
      IDLE: begin
        // live keeps cmd_ready low until the first clock after reset release.
        cmd_ready = live;
`ifdef AXIL_REG_MASTER_TIMEOUT_EN
        m_axi_bready = live;
        m_axi_rready = live;
`endif
        if (live && cmd_valid) state_next = cmd_write ? WR_REQ : RD_REQ;
      end
      WR_REQ: begin
        m_axi_awvalid = !aw_done;
        m_axi_wvalid  = !w_done;
        if ((aw_done || m_axi_awready) && (w_done || m_axi_wready)) state_next = WR_RESP;
      end
      WR_RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid || expired) state_next = RSP;
      end
      RD_REQ: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_next = RD_RESP;
      end
      RD_RESP: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid || expired) state_next = RSP;
      end
      RSP: begin
        rsp_valid = 1'b1;
`ifdef AXIL_REG_MASTER_TIMEOUT_EN
        m_axi_bready = 1'b1;
        m_axi_rready = 1'b1;
`endif
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      // NOTE: the command and response registers are plain flops, so they are reset to 0 with the FSM.
      state     <= IDLE;
      live      <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rsp_rdata <= '0;
      rsp_resp  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_next;
      live  <= 1'b1;
      if (cmd_fire) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (aw_fire) aw_done <= 1'b1;
      if (w_fire)  w_done  <= 1'b1;
      if (state == WR_RESP && m_axi_bvalid) begin
        rsp_rdata <= '0;
        rsp_resp  <= m_axi_bresp;
        timeout_q <= 1'b0;
      end else if (state == RD_RESP && m_axi_rvalid) begin
        rsp_rdata <= m_axi_rdata;
        rsp_resp  <= m_axi_rresp;
        timeout_q <= 1'b0;
      end else if (expired) begin
        rsp_rdata <= '0;
        rsp_resp  <= 2'b10;
        timeout_q <= 1'b1;
      end
    end
  end

  assign m_axi_awaddr = addr_q & ADDR_MASK;
  assign m_axi_araddr = addr_q & ADDR_MASK;
  assign m_axi_wdata  = wdata_q;
  assign m_axi_wstrb  = wstrb_q;
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;
  assign rsp_timeout  = timeout_q;

endmodule

// File: tb/tb_axil_reg_master.sv
// Directed bench for axil_reg_master with a small configurable AXI4-Lite slave model.
// The watchdog scenario runs only when AXIL_REG_MASTER_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_axil_reg_master;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [15:0] m_axi_awaddr, m_axi_araddr;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [31:0] m_axi_wdata, m_axi_rdata;
  logic [3:0]  m_axi_wstrb;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;

  int tests = 0;
  int fails = 0;

  axil_reg_master #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: ready after *_wait cycles of valid, one B per AW+W pair, one R per AR.
  int          aw_wait = 0, w_wait = 0, r_wait = 0;
  bit          b_never = 0, stray_b = 0;
  logic [1:0]  slv_bresp = 2'b00, slv_rresp = 2'b00;
  logic [31:0] slv_rdata = '0;
  int          aw_cnt, w_cnt, r_cnt;
  bit          aw_seen, w_seen, b_pend, r_pend;

  assign m_axi_awready = m_axi_awvalid && (aw_cnt >= aw_wait);
  assign m_axi_wready  = m_axi_wvalid && (w_cnt >= w_wait);
  assign m_axi_arready = m_axi_arvalid;
  assign m_axi_bvalid  = (b_pend && !b_never) || stray_b;
  assign m_axi_bresp   = slv_bresp;
  assign m_axi_rvalid  = r_pend && (r_cnt >= r_wait);
  assign m_axi_rdata   = m_axi_rvalid ? slv_rdata : 32'h0;
  assign m_axi_rresp   = m_axi_rvalid ? slv_rresp : 2'b00;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_cnt <= 0; w_cnt <= 0; r_cnt <= 0;
      aw_seen <= 0; w_seen <= 0; b_pend <= 0; r_pend <= 0;
    end else begin
      aw_cnt <= (m_axi_awvalid && !m_axi_awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (m_axi_wvalid && !m_axi_wready) ? w_cnt + 1 : 0;
      if (m_axi_bvalid && m_axi_bready) b_pend <= 0;
      if ((aw_seen || (m_axi_awvalid && m_axi_awready)) && (w_seen || (m_axi_wvalid && m_axi_wready))) begin
        b_pend <= 1; aw_seen <= 0; w_seen <= 0;
      end else begin
        if (m_axi_awvalid && m_axi_awready) aw_seen <= 1;
        if (m_axi_wvalid && m_axi_wready)   w_seen  <= 1;
      end
      if (m_axi_arvalid && m_axi_arready) begin
        r_pend <= 1; r_cnt <= 0;
      end else if (m_axi_rvalid && m_axi_rready) begin
        r_pend <= 0; r_cnt <= 0;
      end else if (r_pend && !m_axi_rvalid) begin
        r_cnt <= r_cnt + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a command, waits (bounded) for acceptance; returns in cycle N+1.
  task automatic send_cmd(input logic wr, input logic [15:0] addr, input logic [31:0] data,
                          input logic [3:0] strb);
    int n;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    n = 0;
    while (!cmd_ready && n < 20) begin tick(); n++; end
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++; $display("FAIL cmd_accept: cmd_ready=%b after %0d cycles, want 1", cmd_ready, n);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({cmd_ready, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_valid} !== 7'b0) begin
      fails++; $display("FAIL reset_handshakes: got %b, want 0000000",
        {cmd_ready, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_valid});
    end
    tests++;
    if ({rsp_rdata, rsp_resp, rsp_timeout} !== 35'h0) begin
      fails++; $display("FAIL reset_rsp: rdata=%h resp=%b timeout=%b, want all 0", rsp_rdata, rsp_resp, rsp_timeout);
    end
    tests++;
    if ({m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_wstrb} !== 68'h0) begin
      fails++; $display("FAIL reset_bus: awaddr=%h araddr=%h wdata=%h wstrb=%h, want 0",
        m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_wstrb);
    end
    rst_n = 1'b1;
    #2;
    tests++;
    if (cmd_ready !== 1'b0) begin
      fails++; $display("FAIL release_no_edge: cmd_ready=%b, want 0", cmd_ready);
    end
    tick();
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++; $display("FAIL release_first_clock: cmd_ready=%b, want 1", cmd_ready);
    end
  endtask

  task automatic test_write_zero_wait();
    slv_bresp = 2'b00;
    send_cmd(1'b1, 16'h0004, 32'h8000_0000, 4'hF);
    tests++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_awaddr, m_axi_wdata, m_axi_wstrb} !== {2'b11, 16'h0004, 32'h8000_0000, 4'hF}) begin
      fails++; $display("FAIL wr_n1: awv=%b wv=%b awaddr=%h wdata=%h wstrb=%h, want 1 1 0004 80000000 f",
        m_axi_awvalid, m_axi_wvalid, m_axi_awaddr, m_axi_wdata, m_axi_wstrb);
    end
    tests++;
    if ({m_axi_awprot, m_axi_arprot} !== 6'b0) begin
      fails++; $display("FAIL prot: awprot=%b arprot=%b, want 000", m_axi_awprot, m_axi_arprot);
    end
    tick();
    tests++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, rsp_valid} !== 4'b0010) begin
      fails++; $display("FAIL wr_n2: awv,wv,bready,rsp_valid=%b, want 0010",
        {m_axi_awvalid, m_axi_wvalid, m_axi_bready, rsp_valid});
    end
    tick();
    tests++;
    if ({rsp_valid, rsp_resp, rsp_rdata, rsp_timeout} !== {1'b1, 2'b00, 32'h0, 1'b0}) begin
      fails++; $display("FAIL wr_n3_rsp: valid=%b resp=%b rdata=%h timeout=%b, want 1 00 0 0",
        rsp_valid, rsp_resp, rsp_rdata, rsp_timeout);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tests++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      fails++; $display("FAIL wr_done: rsp_valid,cmd_ready=%b, want 01", {rsp_valid, cmd_ready});
    end
  endtask

  task automatic test_read_wait();
    int lat, ar_cycles;
    r_wait = 3; slv_rdata = 32'h00AB_CDEF; slv_rresp = 2'b00;
    send_cmd(1'b0, 16'h0000, 32'h0, 4'h0);
    tests++;
    if ({m_axi_arvalid, m_axi_araddr} !== {1'b1, 16'h0000}) begin
      fails++; $display("FAIL rd_n1: arvalid=%b araddr=%h, want 1 0000", m_axi_arvalid, m_axi_araddr);
    end
    lat = 1; ar_cycles = 0;
    while (!rsp_valid && lat < 30) begin
      if (m_axi_arvalid) ar_cycles++;
      tick(); lat++;
    end
    tests++;
    if (lat != 6) begin
      fails++; $display("FAIL rd_latency: rsp_valid at N+%0d, want N+6", lat);
    end
    tests++;
    if (ar_cycles != 1) begin
      fails++; $display("FAIL rd_arvalid_len: %0d cycles, want 1", ar_cycles);
    end
    tests++;
    if ({rsp_rdata, rsp_resp, rsp_timeout} !== {32'h00AB_CDEF, 2'b00, 1'b0}) begin
      fails++; $display("FAIL rd_payload: rdata=%h resp=%b timeout=%b, want 00abcdef 00 0",
        rsp_rdata, rsp_resp, rsp_timeout);
    end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    r_wait = 0;
  endtask

  task automatic test_write_slow();
    aw_wait = 1; w_wait = 4; slv_bresp = 2'b00;
    send_cmd(1'b1, 16'h0008, 32'h1357_9BDF, 4'h3);
    tick();
    tests++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 3'b110) begin
      fails++; $display("FAIL slow_n2: awv,wv,bready=%b, want 110", {m_axi_awvalid, m_axi_wvalid, m_axi_bready});
    end
    tick();
    tests++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 3'b010) begin
      fails++; $display("FAIL slow_n3: awv,wv,bready=%b, want 010", {m_axi_awvalid, m_axi_wvalid, m_axi_bready});
    end
    tick(); tick();
    tests++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_wdata} !== {3'b010, 32'h1357_9BDF}) begin
      fails++; $display("FAIL slow_n5: awv,wv,bready=%b wdata=%h, want 010 13579bdf",
        {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, m_axi_wdata);
    end
    tick();
    tests++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 3'b001) begin
      fails++; $display("FAIL slow_n6: awv,wv,bready=%b, want 001", {m_axi_awvalid, m_axi_wvalid, m_axi_bready});
    end
    tick();
    tests++;
    if ({rsp_valid, rsp_resp} !== 3'b100) begin
      fails++; $display("FAIL slow_rsp: valid=%b resp=%b, want 1 00", rsp_valid, rsp_resp);
    end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    tick();
    tests++;
    if (rsp_valid !== 1'b0) begin
      fails++; $display("FAIL slow_single_rsp: rsp_valid=%b, want 0", rsp_valid);
    end
    aw_wait = 0; w_wait = 0;
  endtask

  task automatic test_read_error_hold();
    int lat;
    slv_rresp = 2'b10; slv_rdata = 32'h1234_5678;
    send_cmd(1'b0, 16'h0008, 32'h0, 4'h0);
    tests++;
    if (m_axi_araddr !== 16'h0008) begin
      fails++; $display("FAIL hold_araddr: got %h, want 0008", m_axi_araddr);
    end
    lat = 1;
    while (!rsp_valid && lat < 30) begin tick(); lat++; end
    tests++;
    if (lat != 3) begin
      fails++; $display("FAIL hold_latency: rsp_valid at N+%0d, want N+3", lat);
    end
    for (int k = 0; k < 6; k++) begin
      tests++;
      if ({rsp_valid, rsp_resp, rsp_rdata, cmd_ready} !== {1'b1, 2'b10, 32'h1234_5678, 1'b0}) begin
        fails++; $display("FAIL hold_stable_%0d: valid=%b resp=%b rdata=%h cmd_ready=%b, want 1 10 12345678 0",
          k, rsp_valid, rsp_resp, rsp_rdata, cmd_ready);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tests++;
    if (cmd_ready !== 1'b0) begin
      fails++; $display("FAIL hold_ready_same_cycle: cmd_ready=%b, want 0", cmd_ready);
    end
    tick();
    rsp_ready = 1'b0;
    tests++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      fails++; $display("FAIL hold_release: rsp_valid,cmd_ready=%b, want 01", {rsp_valid, cmd_ready});
    end
    slv_rresp = 2'b00;
  endtask

  // Continuous writes with rsp_ready held: one acceptance per 4 cycles, EXOKAY passed through.
  task automatic test_back_to_back();
    int accepts, rsps, prev, bad_gap, bad_addr, bad_resp;
    slv_bresp = 2'b01;
    accepts = 0; rsps = 0; prev = -1; bad_gap = 0; bad_addr = 0; bad_resp = 0;
    cmd_write = 1'b1; cmd_addr = 16'h0013; cmd_wdata = 32'hDEAD_BEEF; cmd_wstrb = 4'hF;
    rsp_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      cmd_valid = (i < 13);
      if (cmd_valid && cmd_ready) begin
        if (prev >= 0 && i - prev != 4) bad_gap++;
        prev = i; accepts++;
      end
      if (m_axi_awvalid && m_axi_awaddr !== 16'h0010) bad_addr++;
      if (rsp_valid) begin
        rsps++;
        if (rsp_resp !== 2'b01) bad_resp++;
      end
      tick();
    end
    rsp_ready = 1'b0;
    tests++;
    if (accepts != 4 || bad_gap != 0) begin
      fails++; $display("FAIL b2b_throughput: accepts=%0d bad_gaps=%0d, want 4 0", accepts, bad_gap);
    end
    tests++;
    if (bad_addr != 0) begin
      fails++; $display("FAIL b2b_awaddr_align: %0d cycles with awaddr != 0010, want 0", bad_addr);
    end
    tests++;
    if (rsps != 4 || bad_resp != 0) begin
      fails++; $display("FAIL b2b_exokay: rsps=%0d bad_resp=%0d, want 4 0", rsps, bad_resp);
    end
    tests++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      fails++; $display("FAIL b2b_idle: cmd_ready,rsp_valid=%b, want 10", {cmd_ready, rsp_valid});
    end
    slv_bresp = 2'b00;
  endtask

  task automatic test_reset_mid();
    int lat;
    aw_wait = 10; w_wait = 10;
    send_cmd(1'b1, 16'h0020, 32'h5555_AAAA, 4'hF);
    tests++;
    if ({m_axi_awvalid, m_axi_wvalid} !== 2'b11) begin
      fails++; $display("FAIL mid_wr_req: awv,wv=%b, want 11", {m_axi_awvalid, m_axi_wvalid});
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({m_axi_awvalid, m_axi_wvalid, rsp_valid, cmd_ready} !== 4'b0) begin
      fails++; $display("FAIL mid_async_drop: awv,wv,rsp_valid,cmd_ready=%b, want 0000",
        {m_axi_awvalid, m_axi_wvalid, rsp_valid, cmd_ready});
    end
    tick();
    rst_n = 1'b1; aw_wait = 0; w_wait = 0;
    tick();
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++; $display("FAIL mid_ready_after: cmd_ready=%b, want 1", cmd_ready);
    end
    slv_rdata = 32'hCAFE_0001; slv_rresp = 2'b00;
    send_cmd(1'b0, 16'h0010, 32'h0, 4'h0);
    lat = 1;
    while (!rsp_valid && lat < 30) begin tick(); lat++; end
    tests++;
    if (lat != 3 || rsp_rdata !== 32'hCAFE_0001 || rsp_resp !== 2'b00) begin
      fails++; $display("FAIL mid_next_read: lat=N+%0d rdata=%h resp=%b, want N+3 cafe0001 00",
        lat, rsp_rdata, rsp_resp);
    end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
  endtask

`ifdef AXIL_REG_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    int lat;
    b_never = 1'b1;
    send_cmd(1'b1, 16'h0030, 32'h0BAD_F00D, 4'hF);
    lat = 1;
    while (!rsp_valid && lat < 40) begin tick(); lat++; end
    tests++;
    if (lat != 16) begin
      fails++; $display("FAIL to_latency: rsp_valid at N+%0d, want N+16", lat);
    end
    tests++;
    if ({rsp_resp, rsp_timeout, rsp_rdata} !== {2'b10, 1'b1, 32'h0}) begin
      fails++; $display("FAIL to_payload: resp=%b timeout=%b rdata=%h, want 10 1 0",
        rsp_resp, rsp_timeout, rsp_rdata);
    end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    tests++;
    if (m_axi_bready !== 1'b1) begin
      fails++; $display("FAIL to_idle_bready: bready=%b, want 1", m_axi_bready);
    end
    b_never = 1'b0;
    tick();
    tests++;
    if ({rsp_valid, cmd_ready, b_pend} !== 3'b010) begin
      fails++; $display("FAIL to_late_b_absorbed: rsp_valid,cmd_ready,b_pend=%b, want 010",
        {rsp_valid, cmd_ready, b_pend});
    end
    send_cmd(1'b1, 16'h0034, 32'h1, 4'h1);
    lat = 1;
    while (!rsp_valid && lat < 40) begin tick(); lat++; end
    tests++;
    if (lat != 3 || rsp_resp !== 2'b00 || rsp_timeout !== 1'b0) begin
      fails++; $display("FAIL to_recover: lat=N+%0d resp=%b timeout=%b, want N+3 00 0", lat, rsp_resp, rsp_timeout);
    end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
  endtask
`else
  task automatic test_stray_b();
    slv_bresp = 2'b11;
    stray_b = 1'b1;
    tests++;
    if (m_axi_bready !== 1'b0) begin
      fails++; $display("FAIL stray_bready: bready=%b, want 0", m_axi_bready);
    end
    tick();
    stray_b = 1'b0;
    tests++;
    if ({rsp_valid, cmd_ready, rsp_resp} !== 4'b0100) begin
      fails++; $display("FAIL stray_ignored: rsp_valid=%b cmd_ready=%b resp=%b, want 0 1 00",
        rsp_valid, cmd_ready, rsp_resp);
    end
    slv_bresp = 2'b00;
  endtask
`endif

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_write_slow();
    test_read_error_hold();
    test_back_to_back();
    test_reset_mid();
`ifdef AXIL_REG_MASTER_TIMEOUT_EN
    test_timeout();
`else
    test_stray_b();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish within 200000 ns");
    $fatal(1, "bench watchdog expired");
  end

endmodule
